// File: rtl/fifo_prog_if.sv
// Producer/consumer side of fifo_prog: push/pop handshake, data and status.
interface fifo_prog_if #(
   parameter int WIDTH = 8,
   parameter int CW    = 5
);
   logic             write;
   logic             read;
   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] data_out;
   logic             data_valid;
   logic             full;
   logic             almost_full;
   logic             empty;
   logic             almost_empty;
   logic [CW-1:0]    cnt;
   logic             overflow;
   logic             underflow;

   modport master (
      output write, read, data_in,
      input  data_out, data_valid, full, almost_full, empty, almost_empty,
             cnt, overflow, underflow
   );

   modport slave (
      input  write, read, data_in,
      output data_out, data_valid, full, almost_full, empty, almost_empty,
             cnt, overflow, underflow
   );
endinterface

// File: rtl/fifo_prog.sv
// Single-clock FIFO with programmable almost thresholds, sticky error flags
// and an optional first-word-fall-through read port.
module fifo_prog #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter bit FWFT  = 1'b0,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   input  logic [CW-1:0] af_thresh,
   input  logic [CW-1:0] ae_thresh,
   fifo_prog_if.slave    bus
);
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic [CW-1:0]    cnt_q;
   logic             ovf_q, udf_q;
   logic             full_w, empty_w, rd_ok, wr_ok;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full_w  = (cnt_q == CW'(DEPTH));
   assign empty_w = (cnt_q == '0);
   assign rd_ok   = bus.read && !empty_w;
   // a full FIFO still takes a write when the same edge frees a slot
   assign wr_ok   = bus.write && (!full_w || rd_ok);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
         udf_q  <= 1'b0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
         udf_q  <= 1'b0;
      end else begin
         if (wr_ok) wr_ptr <= ptr_inc(wr_ptr);
         if (rd_ok) rd_ptr <= ptr_inc(rd_ptr);
         if (wr_ok && !rd_ok)      cnt_q <= cnt_q + CW'(1);
         else if (rd_ok && !wr_ok) cnt_q <= cnt_q - CW'(1);
         if (bus.write && full_w && !rd_ok) ovf_q <= 1'b1;
         if (bus.read && empty_w)           udf_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok && !clear) mem[wr_ptr] <= bus.data_in;
   end

   generate
      if (FWFT) begin : g_fwft
         assign bus.data_out   = empty_w ? '0 : mem[rd_ptr];
         assign bus.data_valid = !empty_w;
      end else begin : g_std
         logic [WIDTH-1:0] dout_q;
         logic             dv_q;

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               dout_q <= '0;
               dv_q   <= 1'b0;
            end else if (clear) begin
               dout_q <= '0;
               dv_q   <= 1'b0;
            end else begin
               dv_q <= rd_ok;
               if (rd_ok) dout_q <= mem[rd_ptr];
            end
         end

         assign bus.data_out   = dout_q;
         assign bus.data_valid = dv_q;
      end
   endgenerate

   assign bus.full         = full_w;
   assign bus.empty        = empty_w;
   assign bus.almost_full  = (cnt_q >= af_thresh);
   assign bus.almost_empty = (cnt_q <= ae_thresh);
   assign bus.cnt          = cnt_q;
   assign bus.overflow     = ovf_q;
   assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_fifo_prog.sv
// Directed bench for fifo_prog: a standard-mode and an FWFT instance, DEPTH=8.
module tb_fifo_prog;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       clear = 1'b0;
   logic [3:0] af_thresh = 4'd6;
   logic [3:0] ae_thresh = 4'd2;
   int         checks = 0;
   int         failures = 0;

   fifo_prog_if #(.WIDTH(8), .CW(4)) bs ();
   fifo_prog_if #(.WIDTH(8), .CW(4)) bf ();

   fifo_prog #(.WIDTH(8), .DEPTH(8), .FWFT(1'b0)) u_std (
      .clk(clk), .reset(reset), .clear(clear),
      .af_thresh(af_thresh), .ae_thresh(ae_thresh), .bus(bs.slave)
   );

   fifo_prog #(.WIDTH(8), .DEPTH(8), .FWFT(1'b1)) u_fw (
      .clk(clk), .reset(reset), .clear(clear),
      .af_thresh(af_thresh), .ae_thresh(ae_thresh), .bus(bf.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         wr;
      bit         rd;
      logic [7:0] din;
      logic [3:0] ecnt;
      bit         efull;
      bit         eempty;
      bit         eaf;
      bit         eae;
      bit         edv;
      logic [7:0] edout;
   } vec_t;

   vec_t vecs[17];

   function automatic vec_t mk(bit wr, bit rd, logic [7:0] din, logic [3:0] ecnt,
                               bit efull, bit eempty, bit eaf, bit eae,
                               bit edv, logic [7:0] edout);
      vec_t v;
      v.wr = wr; v.rd = rd; v.din = din; v.ecnt = ecnt;
      v.efull = efull; v.eempty = eempty; v.eaf = eaf; v.eae = eae;
      v.edv = edv; v.edout = edout;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d);
      bs.write = 1'b1; bs.data_in = d;
      tick();
      bs.write = 1'b0;
   endtask

   logic [7:0] exp_rd [9];

   initial begin
      bs.write = 1'b0; bs.read = 1'b0; bs.data_in = '0;
      bf.write = 1'b0; bf.read = 1'b0; bf.data_in = '0;
      #12 reset = 1'b1;
      #1;

      // reset state
      chk("rst_cnt", bs.cnt, 0);
      chk("rst_empty", bs.empty, 1);
      chk("rst_full", bs.full, 0);
      chk("rst_ae", bs.almost_empty, 1);
      chk("rst_af", bs.almost_full, 0);
      chk("rst_dv", bs.data_valid, 0);
      chk("rst_dout", bs.data_out, 0);
      chk("rst_ovf", bs.overflow, 0);
      chk("rst_udf", bs.underflow, 0);
      chk("rst_fw_dv", bf.data_valid, 0);
      chk("rst_fw_dout", bf.data_out, 0);

      // FWFT: head word visible without a read
      bf.write = 1'b1; bf.data_in = 8'h3C;
      tick();
      bf.write = 1'b0;
      chk("fw_dout_1", bf.data_out, 8'h3C);
      chk("fw_dv_1", bf.data_valid, 1);
      chk("fw_empty_1", bf.empty, 0);
      tick();
      chk("fw_dout_hold", bf.data_out, 8'h3C);
      chk("fw_dv_hold", bf.data_valid, 1);
      bf.write = 1'b1; bf.data_in = 8'h4D;
      tick();
      bf.write = 1'b0;
      chk("fw_dout_2w", bf.data_out, 8'h3C);
      chk("fw_cnt_2w", bf.cnt, 2);
      bf.read = 1'b1;
      tick();
      chk("fw_dout_pop1", bf.data_out, 8'h4D);
      chk("fw_dv_pop1", bf.data_valid, 1);
      tick();
      bf.read = 1'b0;
      chk("fw_empty_pop2", bf.empty, 1);
      chk("fw_dv_pop2", bf.data_valid, 0);
      chk("fw_dout_pop2", bf.data_out, 0);

      // fill 0->8 then drain, af=6 ae=2
      vecs[0]  = mk(1, 0, 8'h01, 1, 0, 0, 0, 1, 0, 8'h00);
      vecs[1]  = mk(1, 0, 8'h02, 2, 0, 0, 0, 1, 0, 8'h00);
      vecs[2]  = mk(1, 0, 8'h03, 3, 0, 0, 0, 0, 0, 8'h00);
      vecs[3]  = mk(1, 0, 8'h04, 4, 0, 0, 0, 0, 0, 8'h00);
      vecs[4]  = mk(1, 0, 8'h05, 5, 0, 0, 0, 0, 0, 8'h00);
      vecs[5]  = mk(1, 0, 8'h06, 6, 0, 0, 1, 0, 0, 8'h00);
      vecs[6]  = mk(1, 0, 8'h07, 7, 0, 0, 1, 0, 0, 8'h00);
      vecs[7]  = mk(1, 0, 8'h08, 8, 1, 0, 1, 0, 0, 8'h00);
      vecs[8]  = mk(0, 1, 8'h00, 7, 0, 0, 1, 0, 1, 8'h01);
      vecs[9]  = mk(0, 1, 8'h00, 6, 0, 0, 1, 0, 1, 8'h02);
      vecs[10] = mk(0, 1, 8'h00, 5, 0, 0, 0, 0, 1, 8'h03);
      vecs[11] = mk(0, 1, 8'h00, 4, 0, 0, 0, 0, 1, 8'h04);
      vecs[12] = mk(0, 1, 8'h00, 3, 0, 0, 0, 0, 1, 8'h05);
      vecs[13] = mk(0, 1, 8'h00, 2, 0, 0, 0, 1, 1, 8'h06);
      vecs[14] = mk(0, 1, 8'h00, 1, 0, 0, 0, 1, 1, 8'h07);
      vecs[15] = mk(0, 1, 8'h00, 0, 0, 1, 0, 1, 1, 8'h08);
      vecs[16] = mk(0, 0, 8'h00, 0, 0, 1, 0, 1, 0, 8'h08);

      for (int i = 0; i < 17; i++) begin
         bs.write = vecs[i].wr; bs.read = vecs[i].rd; bs.data_in = vecs[i].din;
         tick();
         chk($sformatf("v%0d_cnt", i), bs.cnt, vecs[i].ecnt);
         chk($sformatf("v%0d_full", i), bs.full, vecs[i].efull);
         chk($sformatf("v%0d_empty", i), bs.empty, vecs[i].eempty);
         chk($sformatf("v%0d_af", i), bs.almost_full, vecs[i].eaf);
         chk($sformatf("v%0d_ae", i), bs.almost_empty, vecs[i].eae);
         chk($sformatf("v%0d_dv", i), bs.data_valid, vecs[i].edv);
         chk($sformatf("v%0d_dout", i), bs.data_out, vecs[i].edout);
      end
      bs.write = 1'b0; bs.read = 1'b0;

      // overflow, then read+write on a full FIFO
      for (int i = 1; i <= 8; i++) push(8'(i));
      chk("ovf_pre_full", bs.full, 1);
      push(8'hAA);
      chk("ovf_flag", bs.overflow, 1);
      chk("ovf_cnt", bs.cnt, 8);
      bs.write = 1'b1; bs.read = 1'b1; bs.data_in = 8'hBB;
      tick();
      bs.write = 1'b0; bs.read = 1'b0;
      chk("rw_full_cnt", bs.cnt, 8);
      chk("rw_full_dout", bs.data_out, 8'h01);
      exp_rd = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hBB, 8'hBB};
      bs.read = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk($sformatf("drain%0d_dout", i), bs.data_out, exp_rd[i]);
      end
      bs.read = 1'b0;
      chk("drain_empty", bs.empty, 1);
      chk("drain_ovf_sticky", bs.overflow, 1);

      // clear mid-operation, pointers already wrapped, write ignored
      for (int i = 0; i < 5; i++) push(8'h61 + 8'(i));
      chk("clr_pre_cnt", bs.cnt, 5);
      clear = 1'b1; bs.write = 1'b1; bs.data_in = 8'h77;
      tick();
      clear = 1'b0; bs.write = 1'b0;
      chk("clr_cnt", bs.cnt, 0);
      chk("clr_empty", bs.empty, 1);
      chk("clr_ovf", bs.overflow, 0);
      chk("clr_udf", bs.underflow, 0);
      chk("clr_dv", bs.data_valid, 0);
      chk("clr_dout", bs.data_out, 0);

      // underflow with simultaneous write on an empty FIFO
      bs.write = 1'b1; bs.read = 1'b1; bs.data_in = 8'h55;
      tick();
      bs.write = 1'b0;
      chk("udf_flag", bs.underflow, 1);
      chk("udf_cnt", bs.cnt, 1);
      chk("udf_dv", bs.data_valid, 0);
      tick();
      bs.read = 1'b0;
      chk("udf_rd_dout", bs.data_out, 8'h55);
      chk("udf_rd_dv", bs.data_valid, 1);
      chk("udf_rd_cnt", bs.cnt, 0);

      // live threshold changes
      for (int i = 0; i < 4; i++) push(8'h21 + 8'(i));
      chk("thr_af_at4", bs.almost_full, 0);
      af_thresh = 4'd3;
      #1;
      chk("thr_af_live", bs.almost_full, 1);
      for (int i = 4; i < 8; i++) push(8'h21 + 8'(i));
      chk("thr_full", bs.full, 1);
      af_thresh = 4'd9; ae_thresh = 4'd8;
      #1;
      chk("thr_af_over_depth", bs.almost_full, 0);
      chk("thr_ae_at_depth", bs.almost_empty, 1);
      ae_thresh = 4'd2; af_thresh = 4'd0;
      #1;
      chk("thr_ae_full", bs.almost_empty, 0);
      chk("thr_af_zero", bs.almost_full, 1);
      af_thresh = 4'd6;

      // async reset between edges
      bs.read = 1'b1;
      tick();
      bs.read = 1'b0;
      chk("ar_pre_dout", bs.data_out, 8'h21);
      chk("ar_pre_udf", bs.underflow, 1);
      #1 reset = 1'b0;
      #1;
      chk("ar_cnt", bs.cnt, 0);
      chk("ar_empty", bs.empty, 1);
      chk("ar_dout", bs.data_out, 0);
      chk("ar_dv", bs.data_valid, 0);
      chk("ar_udf", bs.underflow, 0);
      chk("ar_no_edge", clk, 1);
      #2 reset = 1'b1;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
